// File: rtl/linear_layer_q_fifo_pkg.sv
// rtl/linear_layer_q_fifo_pkg.sv - shared sizing helpers and parameter checks for the shift-register FIFO
package linear_layer_q_fifo_pkg;

   localparam int DATA_WIDTH_DEF = 304;
   localparam int ADDR_WIDTH_DEF = 2;
   localparam int DEPTH_DEF      = 2;
   localparam int CNT_W          = ADDR_WIDTH_DEF + 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // The count must reach DEPTH itself, so it needs one bit more than the address.
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic bit params_legal(input int addr_width, input int depth);
      return (depth >= 1) && (clog2(depth) <= addr_width);
   endfunction

endpackage

// File: rtl/linear_layer_q_srl_store.sv
// rtl/linear_layer_q_srl_store.sv - shift-register word array, new word enters index 0, no reset
module linear_layer_q_srl_store #(
   parameter int DATA_WIDTH = 304,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int N = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[0] <= din;
         for (int i = 1; i < N; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   assign dout = mem_q[addr];

endmodule

// File: rtl/linear_layer_q_fifo_srl.sv
// rtl/linear_layer_q_fifo_srl.sv - show-ahead FIFO control around SRL storage; LINEAR_LAYER_FIFO_STATS_EN adds stats ports
module linear_layer_q_fifo_srl
   import linear_layer_q_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout
`ifdef LINEAR_LAYER_FIFO_STATS_EN
   ,
   output logic                  if_overflow,
   output logic                  if_underflow,
   output logic [ADDR_WIDTH:0]   if_max_cnt
`endif
);

   localparam int CW = cnt_width(ADDR_WIDTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if (!params_legal(ADDR_WIDTH, DEPTH)) begin : g_bad_params
      $error("linear_layer_q_fifo_srl: DEPTH must be >= 1 and fit in ADDR_WIDTH");
   end

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  full_n_q, empty_n_q;
   logic                  push, pop;

   always_comb begin
      push  = if_write & if_write_ce & full_n_q;
      pop   = if_read & if_read_ce & empty_n_q;
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      // Oldest word sits at cnt-1; a simultaneous shift keeps the address pointing at the next-oldest.
      addr_d = (cnt_d == '0) ? '0 : ADDR_WIDTH'(cnt_d - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         full_n_q  <= (cnt_d != FULL_CNT);
         empty_n_q <= (cnt_d != '0);
      end
   end

   assign if_full_n  = full_n_q;
   assign if_empty_n = empty_n_q;

   linear_layer_q_srl_store #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_store (
      .clk  (clk),
      .we   (push),
      .addr (addr_q),
      .din  (if_din),
      .dout (if_dout)
   );

`ifdef LINEAR_LAYER_FIFO_STATS_EN
   logic          overflow_q, underflow_q;
   logic [CW-1:0] max_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         max_cnt_q   <= '0;
      end else begin
         if (if_write && if_write_ce && !full_n_q) overflow_q  <= 1'b1;
         if (if_read && if_read_ce && !empty_n_q)  underflow_q <= 1'b1;
         if (cnt_d > max_cnt_q)                    max_cnt_q   <= cnt_d;
      end
   end

   assign if_overflow  = overflow_q;
   assign if_underflow = underflow_q;
   assign if_max_cnt   = max_cnt_q;
`endif

endmodule

// File: tb/tb_linear_layer_q_fifo_srl.sv
// tb/tb_linear_layer_q_fifo_srl.sv - scoreboard bench for the shift-register FIFO (LINEAR_LAYER_FIFO_STATS_EN optional)
module tb_linear_layer_q_fifo_srl;

   localparam int DW    = 304;
   localparam int AW    = 2;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_full_n, if_empty_n;
   logic          if_write_ce = 1'b0, if_write = 1'b0;
   logic          if_read_ce = 1'b0, if_read = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic [DW-1:0] if_dout;
`ifdef LINEAR_LAYER_FIFO_STATS_EN
   logic          if_overflow, if_underflow;
   logic [AW:0]   if_max_cnt;
`endif

   linear_layer_q_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .if_full_n   (if_full_n),
      .if_write_ce (if_write_ce),
      .if_write    (if_write),
      .if_din      (if_din),
      .if_empty_n  (if_empty_n),
      .if_read_ce  (if_read_ce),
      .if_read     (if_read),
      .if_dout     (if_dout)
`ifdef LINEAR_LAYER_FIFO_STATS_EN
      ,
      .if_overflow (if_overflow),
      .if_underflow(if_underflow),
      .if_max_cnt  (if_max_cnt)
`endif
   );

   always #5 clk = ~clk;

   int            tests_run = 0;
   int            failures  = 0;
   logic [DW-1:0] exp_q [$];
   int            mcnt = 0;
   logic [DW-1:0] cap_dout, pop_exp;
   bit            popped, pushed;

   // Drives one cycle and advances the reference queue; comparisons stay in the tests.
   task automatic drive(input bit wr, input bit wce, input logic [DW-1:0] din,
                        input bit rd, input bit rce);
      if_write    = wr;
      if_write_ce = wce;
      if_din      = din;
      if_read     = rd;
      if_read_ce  = rce;
      popped      = rd && rce && (mcnt != 0);
      pushed      = wr && wce && (mcnt != DEPTH);
      cap_dout    = if_dout;
      if (popped) pop_exp = exp_q.pop_front();
      if (pushed) exp_q.push_back(din);
      mcnt = exp_q.size();
      @(posedge clk);
      #1;
      if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      mcnt = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         if_write = 1'($urandom); if_write_ce = 1'($urandom);
         if_read  = 1'($urandom); if_read_ce  = 1'($urandom);
         if_din   = DW'($urandom);
         @(posedge clk);
         #1;
         tests_run++;
         if (if_full_n !== 1'b1 || if_empty_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags cyc%0d: full_n=%b empty_n=%b required 1/0", i, if_full_n, if_empty_n);
         end
      end
      reset = 1'b0;
      exp_q.delete();
      mcnt = 0;
      drive(0, 0, '0, 0, 0);
      tests_run++;
      if (if_full_n !== 1'b1 || if_empty_n !== 1'b0) begin
         failures++;
         $display("FAIL reset_after: full_n=%b empty_n=%b required 1/0", if_full_n, if_empty_n);
      end
`ifdef LINEAR_LAYER_FIFO_STATS_EN
      tests_run++;
      if (if_overflow !== 1'b0 || if_underflow !== 1'b0 || if_max_cnt !== '0) begin
         failures++;
         $display("FAIL reset_stats: ovf=%b unf=%b max=%0d required 0/0/0", if_overflow, if_underflow, if_max_cnt);
      end
`endif
   endtask

   task automatic test_fill();
      drive(1, 1, DW'(32'hA), 0, 0);
      tests_run++;
      if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== exp_q[0]) begin
         failures++;
         $display("FAIL fill_first: empty_n=%b full_n=%b dout=%h required 1/1/%h", if_empty_n, if_full_n, if_dout, exp_q[0]);
      end
      drive(1, 1, DW'(32'hB), 0, 0);
      tests_run++;
      if (if_full_n !== 1'b0 || if_dout !== exp_q[0]) begin
         failures++;
         $display("FAIL fill_full: full_n=%b dout=%h required 0/%h", if_full_n, if_dout, exp_q[0]);
      end
      drive(1, 1, DW'(32'hC), 0, 0);
      tests_run++;
      if (if_full_n !== 1'b0 || if_empty_n !== 1'b1 || if_dout !== DW'(32'hA) || mcnt != 2) begin
         failures++;
         $display("FAIL fill_drop: full_n=%b empty_n=%b dout=%h required 0/1/a", if_full_n, if_empty_n, if_dout);
      end
`ifdef LINEAR_LAYER_FIFO_STATS_EN
      tests_run++;
      if (if_overflow !== 1'b1 || if_max_cnt !== 3'd2) begin
         failures++;
         $display("FAIL fill_stats: ovf=%b max=%0d required 1/2", if_overflow, if_max_cnt);
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, '0, 1, 1);
         tests_run++;
         if (!popped || cap_dout !== pop_exp) begin
            failures++;
            $display("FAIL drain_word%0d: dout=%h required %h", i, cap_dout, pop_exp);
         end
      end
      tests_run++;
      if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
         failures++;
         $display("FAIL drain_flags: empty_n=%b full_n=%b required 0/1", if_empty_n, if_full_n);
      end
      drive(0, 0, '0, 1, 1);
      tests_run++;
      if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
         failures++;
         $display("FAIL empty_read: empty_n=%b full_n=%b required 0/1", if_empty_n, if_full_n);
      end
`ifdef LINEAR_LAYER_FIFO_STATS_EN
      tests_run++;
      if (if_underflow !== 1'b1) begin
         failures++;
         $display("FAIL underflow_flag: unf=%b required 1", if_underflow);
      end
`endif
      drive(1, 1, DW'(32'h77), 1, 1);
      tests_run++;
      if (if_empty_n !== 1'b1 || if_dout !== DW'(32'h77)) begin
         failures++;
         $display("FAIL empty_read_write: empty_n=%b dout=%h required 1/77", if_empty_n, if_dout);
      end
      drive(1, 1, DW'(32'h78), 0, 0);
      drive(1, 1, DW'(32'h99), 1, 1);
      tests_run++;
      if (!popped || cap_dout !== pop_exp || if_dout !== DW'(32'h78) || if_full_n !== 1'b1 || mcnt != 1) begin
         failures++;
         $display("FAIL full_push_pop: popped=%h dout=%h full_n=%b required 77/78/1", cap_dout, if_dout, if_full_n);
      end
      drive(0, 0, '0, 1, 1);
   endtask

   task automatic test_streaming();
      int delivered = 0;
      pulse_reset();
      for (int i = 0; i < 100; i++) begin
         drive(1, 1, {$urandom, 240'(i + 256)}, 1, 1);
         if (popped) begin
            delivered++;
            tests_run++;
            if (cap_dout !== pop_exp) begin
               failures++;
               $display("FAIL stream_word%0d: dout=%h required %h", i, cap_dout, pop_exp);
            end
         end
         if (i > 0 && !popped) begin
            failures++;
            $display("FAIL stream_bubble%0d: no word delivered, required one", i);
         end
         if (if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
            failures++;
            $display("FAIL stream_flags%0d: empty_n=%b full_n=%b required 1/1", i, if_empty_n, if_full_n);
         end
      end
      drive(0, 0, '0, 1, 1);
      if (popped) delivered++;
      tests_run++;
      if (delivered != 100 || cap_dout !== pop_exp || if_empty_n !== 1'b0) begin
         failures++;
         $display("FAIL stream_total: delivered=%0d empty_n=%b required 100/0", delivered, if_empty_n);
      end
`ifdef LINEAR_LAYER_FIFO_STATS_EN
      tests_run++;
      if (if_max_cnt !== 3'd1) begin
         failures++;
         $display("FAIL stream_max_cnt: max=%0d required 1", if_max_cnt);
      end
`endif
   endtask

   task automatic test_ce_gating();
      drive(1, 1, DW'(32'h33), 0, 0);
      drive(1, 0, DW'(32'h44), 1, 0);
      tests_run++;
      if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== DW'(32'h33) || mcnt != 1) begin
         failures++;
         $display("FAIL ce_gating: empty_n=%b full_n=%b dout=%h required 1/1/33", if_empty_n, if_full_n, if_dout);
      end
      drive(0, 0, '0, 1, 1);
      tests_run++;
      if (cap_dout !== pop_exp || if_empty_n !== 1'b0) begin
         failures++;
         $display("FAIL ce_drain: dout=%h empty_n=%b required %h/0", cap_dout, if_empty_n, pop_exp);
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 1, DW'(32'h11), 0, 0);
      drive(1, 1, DW'(32'h22), 0, 0);
      pulse_reset();
      tests_run++;
      if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
         failures++;
         $display("FAIL midreset_flags: empty_n=%b full_n=%b required 0/1", if_empty_n, if_full_n);
      end
      drive(1, 1, DW'(32'h5), 0, 0);
      tests_run++;
      if (if_dout !== DW'(32'h5) || if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
         failures++;
         $display("FAIL midreset_push: dout=%h empty_n=%b full_n=%b required 5/1/1", if_dout, if_empty_n, if_full_n);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_ce_gating();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
